// File: rtl/resp_router_pkg.sv
// resp_router_pkg: shared constants and helpers for the response router.
//   N_PORTS_DEF / DATA_W_DEF / DEPTH_DEF : default parameter values
//   onehot_to_idx                        : one-hot vector -> bit index
package resp_router_pkg;

    localparam int N_PORTS_DEF = 4;
    localparam int DATA_W_DEF  = 64;
    localparam int DEPTH_DEF   = 4;

    // ORs together the indices of all set bits. For a one-hot input this
    // is exactly the index of the set bit; for anything else the result
    // is meaningless (and the caller treats it as undefined).
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/resp_router_ord_fifo.sv
// ord_fifo: in-order register-array FIFO holding one-hot grant tags.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, wdata       write request and data (ignored while full)
//   pop               read advance (ignored while empty)
//   rdata             entry at the read pointer (head)
//   full, empty       occupancy flags derived from the registered count
//   count             number of stored entries
module ord_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset: an entry is only observed after it is written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/resp_router.sv
// resp_router: steers responses from one shared downstream port back to
// the requester that issued the matching request, using an in-order FIFO
// of one-hot grant tags captured when requests fire.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   req_fire, req_grant     request accepted downstream + its one-hot grant
//   ord_full, outstanding   tag FIFO full flag and occupancy
//   resp_valid/ready/data   shared downstream response channel
//   port_valid/ready/data   per-requester response channels (data shared)
//   err_orphan              sticky: response seen with nothing outstanding
// Build option RESP_ROUTER_BURST_EN adds resp_last/port_last; the head tag
// is then retired only on the last beat of a burst.
module resp_router
    import resp_router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_fire,
    input  logic [N_PORTS-1:0]       req_grant,
    output logic                     ord_full,
    output logic [$clog2(DEPTH):0]   outstanding,
    input  logic                     resp_valid,
    output logic                     resp_ready,
    input  logic [DATA_W-1:0]        resp_data,
`ifdef RESP_ROUTER_BURST_EN
    input  logic                     resp_last,
    output logic [N_PORTS-1:0]       port_last,
`endif
    output logic [N_PORTS-1:0]       port_valid,
    input  logic [N_PORTS-1:0]       port_ready,
    output logic [DATA_W-1:0]        port_data,
    output logic                     err_orphan
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0] head;
    logic [IDX_W-1:0]   head_idx;
    logic               empty;
    logic               beat;
    logic               pop;

    ord_fifo #(
        .WIDTH (N_PORTS),
        .DEPTH (DEPTH)
    ) u_ord_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (req_grant),
        .pop   (pop),
        .rdata (head),
        .full  (ord_full),
        .empty (empty),
        .count (outstanding)
    );

    assign head_idx   = IDX_W'(onehot_to_idx(32'(head)));
    assign port_valid = {N_PORTS{resp_valid & ~empty}} & head;
    // |head keeps a (never expected) all-zero tag from reading port_ready[0].
    assign resp_ready = ~empty & (|head) & port_ready[head_idx];
    assign port_data  = resp_data;
    assign beat       = resp_valid & resp_ready;

`ifdef RESP_ROUTER_BURST_EN
    assign port_last  = {N_PORTS{resp_last}} & head;
    assign pop        = beat & resp_last;
`else
    assign pop        = beat;
`endif

    // A push landing in an empty FIFO in the same cycle means the response
    // belongs to it and is merely early; only flag a truly unmatched one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (resp_valid & empty & ~req_fire) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: doc/resp_router.md
Name: resp_router

Overview:
- Return-path companion to the round-robin request arbiter.
- Records the one-hot grant of every request accepted downstream in an in-order tag FIFO.
- Steers each response from the single shared downstream port back to the requester that issued it.
- Sits between the shared memory/bus responder and the N requester response channels, mirroring the arbiter on the request side.

Parameters:
- N_PORTS, 4, number of requesters; must match the arbiter WIDTH.
- DATA_W, 64, response payload width.
- DEPTH, 4, maximum outstanding requests; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_fire  in  1  a request was accepted downstream this cycle.
- req_grant  in  N_PORTS  one-hot grant of that request; sampled only when req_fire=1.
- ord_full  out  1  tag FIFO full; the arbiter must withhold enable/req_fire while it is set.
- outstanding  out  $clog2(DEPTH)+1  number of entries in the tag FIFO.
- resp_valid  in  1  downstream response valid.
- resp_ready  out  1  downstream response ready.
- resp_data  in  DATA_W  downstream response payload.
- port_valid  out  N_PORTS  per-requester response valid.
- port_ready  in  N_PORTS  per-requester response ready.
- port_data  out  DATA_W  shared payload, driven to all ports.
- err_orphan  out  1  sticky: a response arrived with no outstanding request.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: FIFO pointers 0, outstanding=0, ord_full=0, err_orphan=0. Consequently port_valid=0 and resp_ready=0.
- Push: when req_fire=1 and ord_full=0, write req_grant at the write pointer. The entry is visible at the head the next cycle; there is no same-cycle bypass.
- req_fire while ord_full=1 is dropped; the FIFO is unchanged. The bench flags this as a protocol violation.
- Routing (combinational, zero latency), with empty = (outstanding==0) and head = the one-hot entry at the read pointer:
  - port_valid[i] = resp_valid & !empty & head[i]
  - resp_ready = !empty & |(head & port_ready)
  - port_data = resp_data
- Pop: on a beat handshake (resp_valid & resp_ready), advance the read pointer (subject to RESP_BURST_EN).
- Simultaneous push and pop:
  - If not full, outstanding is unchanged and both pointers advance.
  - If full, the push is rejected and the pop proceeds. ord_full is registered state and does not deassert combinationally.
- Empty with resp_valid=1: resp_ready=0 (the response stalls) and err_orphan sets, staying set until rst.
- Same-cycle push into an empty FIFO with resp_valid: the response stalls this cycle and routes next cycle; err_orphan does not set.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- ord_full = (outstanding==DEPTH).
- A non-one-hot req_grant is stored as-is. Behaviour in that case is undefined; the bench asserts one-hot.
- Reset mid-operation: all outstanding tags are discarded and the outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: RESP_ROUTER_BURST_EN.
- Defined: adds input resp_last (1 bit) and output port_last (N_PORTS), with port_last[i] = resp_last & head[i]. The read pointer advances only on a handshake with resp_last=1, so a multi-beat burst stays routed to one requester.
- Undefined: no resp_last or port_last ports; every accepted beat pops one entry.

Decomposition:
- Shared package resp_router_pkg holds:
  - the default constants N_PORTS_DEF=4, DATA_W_DEF=64, DEPTH_DEF=4;
  - a function onehot_to_idx used for head decode.
- One sub-module: ord_fifo, a synchronous register-array FIFO with width N_PORTS, parameter DEPTH, push/pop/full/empty/count, and asynchronous active-high reset. resp_router instantiates it and adds the routing logic.

Test Plan:
- Reset: assert rst with resp_valid=1 -> port_valid=0, resp_ready=0, outstanding=0, err_orphan=0.
- Single transaction: push grant 4'b0100; next cycle resp_valid=1, data=64'hDEAD, port_ready=4'b0100 -> port_valid=4'b0100, port_data=64'hDEAD, resp_ready=1, outstanding 1->0.
- Ordering and backpressure: push 0001, 1000, 0010; responses D1, D2, D3 -> each routed to port 0, 3, 1 in order. With port_ready[3]=0 for 3 cycles, resp_ready=0 and D2 is held with no reorder.
- Full and wrap: push 4 entries -> ord_full=1; a 5th req_fire is ignored. Push and pop in the same full cycle -> outstanding=3. Run 10 push/pop pairs -> routing stays correct across pointer wrap.
- Orphan: resp_valid=1 with the FIFO empty -> resp_ready=0, err_orphan=1 next cycle and held after subsequent normal traffic.
- RESP_ROUTER_BURST_EN: grant 0010 with a 4-beat burst, resp_last on beat 4 -> all 4 beats go to port 1 and outstanding decrements only after beat 4.
